freq_seg_scan: RTL and testbench

//   Consumes the 32-bit packed BCD word from the frequency-embed stage and drives it

---
 rtl/freq_seg_scan.sv | 96 +++++++++
 tb/tb_freq_seg_scan.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_seg_scan.sv
// Multiplexed 8-digit 7-segment driver for the packed BCD frequency word.
// Digits 7..4 carry the measured frequency, 3..0 the theoretical one; the word is snapshotted once per frame.
module freq_seg_scan #(
  parameter int SCAN_DIV   = 10,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic        clk_10k,
  input  logic        rst_n,
  input  logic [31:0] freq_data,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [31:0]   snapshot;
  logic [7:0]    keep;
  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    an_nxt;
  logic [7:0]    seg_nxt;

  // keep[i]=1 when digit i or a digit above it in the same group is non-zero;
  // a cleared flag means "still inside the leading zeros".
  function automatic logic [7:0] keep_of(input logic [31:0] v);
    logic [7:0] k;
    k[7] = |v[31:28];
    k[6] = k[7] | (|v[27:24]);
    k[5] = k[6] | (|v[23:20]);
    k[4] = 1'b1;
    k[3] = |v[15:12];
    k[2] = k[3] | (|v[11:8]);
    k[1] = k[2] | (|v[7:4]);
    k[0] = 1'b1;
    return k;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  assign tick = (prescaler == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == 3'd7);

  always_comb begin
    nib     = snapshot[{idx, 2'b00} +: 4];
    // Ones digits (idx 4 and 0) are never blanked.
    blank   = BLANK_LZ && (idx[1:0] != 2'b00) && !keep[idx];
    an_nxt  = 8'h01 << idx;
    seg_nxt = {(idx == 3'd4), (blank ? 7'b0000000 : decode(nib))};
  end

  always_ff @(posedge clk_10k) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      snapshot   <= '0;
      keep       <= '0;
      frame_done <= 1'b0;
      an         <= {8{ACTIVE_LOW}};
      seg        <= {8{ACTIVE_LOW}};
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= wrap;
      if (tick) idx <= idx + 3'd1;
      if (wrap && !hold) begin
        snapshot <= freq_data;
        keep     <= keep_of(freq_data);
      end
      an  <= an_nxt  ^ {8{ACTIVE_LOW}};
      seg <= seg_nxt ^ {8{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_freq_seg_scan.sv
// Self-checking bench for freq_seg_scan: a time-based reference model predicts
// every an/seg/frame_done value from the cycle count since reset.
module tb_freq_seg_scan;
  localparam int D     = 10;
  localparam int FRAME = 8 * D;

  logic        clk_10k = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] freq_data = '0;
  logic        hold = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m = 0;
  logic [31:0] msnap = '0;
  logic [31:0] cur_fd = '0;
  logic        cur_hd = 1'b0;
  logic [7:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_fd;

  freq_seg_scan #(.SCAN_DIV(D), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk_10k(clk_10k), .rst_n(rst_n), .freq_data(freq_data), .hold(hold),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk_10k = ~clk_10k;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    return tbl[n];
  endfunction

  // Active-high expected pattern of digit i for a given snapshot word.
  function automatic logic [7:0] exp_pat(input logic [31:0] s, input int i);
    int   top;
    logic blank;
    top   = (i >= 4) ? 7 : 3;
    blank = 1'b0;
    if (i != top - 3) begin
      blank = 1'b1;
      for (int j = top; j >= i; j--)
        if (s[4*j +: 4] != 4'd0) blank = 1'b0;
    end
    return {(i == 4), (blank ? 7'h00 : seg7(s[4*i +: 4]))};
  endfunction

  // Advance one clock and update the model; called right after a negedge.
  task automatic step(input logic [31:0] fd, input logic hd);
    int   dig;
    logic [31:0] shown;
    freq_data = fd;
    hold      = hd;
    cur_fd    = fd;
    cur_hd    = hd;
    @(posedge clk_10k);
    m++;
    dig    = ((m - 1) / D) % 8;
    shown  = msnap;
    exp_fd = ((m % FRAME) == 0);
    if (exp_fd && !hd) msnap = fd;
    exp_an  = ~(8'h01 << dig);
    exp_seg = ~exp_pat(shown, dig);
    @(negedge clk_10k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_10k);
      @(negedge clk_10k);
      checks++;
      if ({an, seg, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs: an=%h seg=%h fd=%b expected an=ff seg=ff fd=0", an, seg, frame_done);
      end
    end
    rst_n = 1'b1;
    m = 0;
    msnap = '0;
    for (int i = 0; i < FRAME; i++) begin
      step(32'h0, 1'b0);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL reset_frame m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_scan();
    int cnt [8];
    int per;
    bit seen;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(32'h1234_0567, 1'b0);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL scan m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (i >= FRAME)
        for (int d = 0; d < 8; d++) if (an == ~(8'h01 << d)) cnt[d]++;
    end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cnt[d] != D) begin
        errors++;
        $display("FAIL scan_dwell digit %0d: %0d cycles, expected %0d", d, cnt[d], D);
      end
    end
    // frame_done period, bounded
    per = 0;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !(seen && frame_done && per > 0); i++) begin
      step(32'h1234_0567, 1'b0);
      if (seen) per++;
      if (frame_done && !seen) seen = 1;
    end
    checks++;
    if (per != FRAME) begin
      errors++;
      $display("FAIL scan_period: %0d cycles, expected %0d", per, FRAME);
    end
  endtask

  task automatic test_blanking();
    logic [7:0] want [8];
    want = '{8'h3F, 8'h3F, 8'h06, 8'h00, 8'hEF, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(32'h0009_0100, 1'b0);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL blanking m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (i >= FRAME + 2)
        for (int d = 0; d < 8; d++)
          if (an == ~(8'h01 << d)) begin
            checks++;
            if (seg !== ~want[d]) begin
              errors++;
              $display("FAIL blanking_digit %0d: seg=%h expected %h", d, seg, ~want[d]);
            end
          end
    end
  endtask

  task automatic test_tearing();
    logic [31:0] fd;
    bit hit;
    fd = 32'h1111_1111;
    for (int i = 0; i < FRAME + 5; i++) step(fd, 1'b0);
    for (int i = 0; i < FRAME && (((m / D) % 8) != 3); i++) step(fd, 1'b0);
    fd = 32'h2222_2222;
    hit = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(fd, 1'b0);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL tearing m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (!hit && an == 8'h7F) begin
        hit = 1;
        checks++;
        if (seg !== ~8'h06) begin
          errors++;
          $display("FAIL tearing_old_digit7: seg=%h expected %h", seg, ~8'h06);
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL tearing_digit7_seen: not observed, expected observed");
    end
  endtask

  task automatic test_hold_invalid();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(32'hABCD_0000, 1'b1);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL hold m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (an == 8'hFE) begin
        checks++;
        if (seg !== ~8'h5B) begin
          errors++;
          $display("FAIL hold_frozen digit0: seg=%h expected %h", seg, ~8'h5B);
        end
      end
    end
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step(32'hABCD_0000, 1'b0);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL invalid m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (i >= FRAME + 2 && an == 8'hEF) begin
        checks++;
        if (seg !== ~8'hC0) begin
          errors++;
          $display("FAIL invalid_digit4: seg=%h expected %h", seg, ~8'hC0);
        end
      end
      if (i >= FRAME + 2 && an == 8'hFD) begin
        checks++;
        if (seg !== 8'hFF) begin
          errors++;
          $display("FAIL invalid_theo_blank digit1: seg=%h expected ff", seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] fd;
    logic        hd;
    fd = $urandom;
    hd = 1'b0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) fd = $urandom;
      if ($urandom_range(0, 7) == 0) fd[4*$urandom_range(0, 7) +: 4] = 4'd0;
      if ($urandom_range(0, 31) == 0) fd = fd & 32'h000F_000F;
      if ($urandom_range(0, 63) == 0) hd = ~hd;
      step(fd, hd);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL random m=%0d fd=%h hold=%b: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, cur_fd, cur_hd, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2 * FRAME && (((m / D) % 8) != 5); i++) step(32'h8765_4321, 1'b0);
    rst_n = 1'b0;
    @(posedge clk_10k);
    @(negedge clk_10k);
    checks++;
    if ({an, seg, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: an=%h seg=%h fd=%b expected an=ff seg=ff fd=0", an, seg, frame_done);
    end
    rst_n = 1'b1;
    m = 0;
    msnap = '0;
    for (int i = 0; i < FRAME + 3; i++) begin
      step(32'h8765_4321, 1'b0);
      checks++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL mid_reset_restart m=%0d: an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 m, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  endtask

  initial begin
    @(negedge clk_10k);
    test_reset();
    test_scan();
    test_blanking();
    test_tearing();
    test_hold_invalid();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
